// File: rtl/inequality_cmp_pkg.sv
// Shared constants and result type for the inequality comparator.
package inequality_cmp_pkg;

  localparam int unsigned RES_W  = 3;
  localparam int unsigned GT_BIT = 2;
  localparam int unsigned EQ_BIT = 1;
  localparam int unsigned LT_BIT = 0;

  typedef logic [RES_W-1:0] cmp_result_t;

  localparam cmp_result_t CMP_NONE = 3'b000;

endpackage

// File: rtl/inequality_core.sv
// Combinational one-hot magnitude compare of a against b.
// INEQUALITY_CMP_SIGNED_EN selects two's-complement compare; default is unsigned.
module inequality_core
  import inequality_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output cmp_result_t      res
);

  always_comb begin
    res = CMP_NONE;
`ifdef INEQUALITY_CMP_SIGNED_EN
    res[GT_BIT] = $signed(a) >  $signed(b);
    res[EQ_BIT] = a == b;
    res[LT_BIT] = $signed(a) <  $signed(b);
`else
    res[GT_BIT] = a >  b;
    res[EQ_BIT] = a == b;
    res[LT_BIT] = a <  b;
`endif
  end

endmodule

// File: rtl/inequality_cmp.sv
// Registered comparator: classifies num against a loadable threshold, 1-cycle latency.
// Optional build macro: INEQUALITY_CMP_SIGNED_EN (signed compare inside inequality_core).
module inequality_cmp
  import inequality_cmp_pkg::*;
#(
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned THRESH_DEFAULT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             num_valid,
  input  logic [WIDTH-1:0] num,
  input  logic             thr_load,
  input  logic [WIDTH-1:0] thr_in,
  output logic             out_valid,
  output logic [2:0]       out,
  output logic [WIDTH-1:0] thr
);

  localparam logic [WIDTH-1:0] THR_RST = WIDTH'(THRESH_DEFAULT);

  cmp_result_t      res_c;
  cmp_result_t      out_d, out_q;
  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] thr_d, thr_q;

  // Compare always uses the threshold held before this edge.
  inequality_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a   (num),
    .b   (thr_q),
    .res (res_c)
  );

  always_comb begin
    out_d       = out_q;
    out_valid_d = 1'b0;
    thr_d       = thr_q;
    if (num_valid) begin
      out_d       = res_c;
      out_valid_d = 1'b1;
    end
    if (thr_load) begin
      thr_d = thr_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= CMP_NONE;
      out_valid_q <= 1'b0;
      thr_q       <= THR_RST;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      thr_q       <= thr_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign thr       = thr_q;

endmodule

// File: tb/tb_inequality_cmp.sv
// Self-checking bench for inequality_cmp against an integer-arithmetic reference model.
module tb_inequality_cmp;

  localparam int W  = 4;
  localparam int TD = 8;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         num_valid;
  logic [W-1:0] num;
  logic         thr_load;
  logic [W-1:0] thr_in;
  logic         out_valid;
  logic [2:0]   out;
  logic [W-1:0] thr;

  int total  = 0;
  int passed = 0;

  // Reference model state
  int         m_thr;
  logic [2:0] m_out;
  logic       m_valid;

  always #5 clk = ~clk;

  inequality_cmp #(
    .WIDTH          (W),
    .THRESH_DEFAULT (TD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .num_valid (num_valid),
    .num       (num),
    .thr_load  (thr_load),
    .thr_in    (thr_in),
    .out_valid (out_valid),
    .out       (out),
    .thr       (thr)
  );

  // Numeric value of a raw W-bit pattern in the active build's interpretation.
  function automatic int val(input int raw);
`ifdef INEQUALITY_CMP_SIGNED_EN
    return (raw >= (1 << (W - 1))) ? raw - (1 << W) : raw;
`else
    return raw;
`endif
  endfunction

  function automatic logic [2:0] ref_cmp(input int n, input int t);
    int a, b;
    a = val(n);
    b = val(t);
    if (a > b)       return 3'b100;
    else if (a == b) return 3'b010;
    else             return 3'b001;
  endfunction

  // Apply one cycle of inputs, advance the model on the edge, settle 1 time unit after.
  task automatic cycle(input bit rv, input bit nv, input int n, input bit tl, input int ti);
    rst_n     = rv;
    num_valid = nv;
    num       = W'(n);
    thr_load  = tl;
    thr_in    = W'(ti);
    @(posedge clk);
    if (!rv) begin
      m_out   = 3'b000;
      m_valid = 1'b0;
      m_thr   = TD % (1 << W);
    end else begin
      if (nv) begin
        m_out   = ref_cmp(n, m_thr);
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (tl) m_thr = ti;
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b1, 3, 1'b1, 2);
    cycle(1'b0, 1'b0, 0, 1'b0, 0);
    total++; if (out !== 3'b000) $display("FAIL reset out: got %b want 000", out); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b want 0", out_valid); else passed++;
    total++; if (thr !== 4'd8) $display("FAIL reset thr: got %0d want 8", thr); else passed++;
  endtask

  task automatic test_single();
    cycle(1'b1, 1'b1, 5, 1'b0, 0);
    total++; if (out !== m_out) $display("FAIL single out: got %b want %b", out, m_out); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL single out_valid: got %b want 1", out_valid); else passed++;
    cycle(1'b1, 1'b0, 0, 1'b0, 0);
    total++; if (out !== m_out) $display("FAIL idle hold out: got %b want %b", out, m_out); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL idle out_valid: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    int seq[3] = '{8, 15, 0};
    foreach (seq[i]) begin
      cycle(1'b1, 1'b1, seq[i], 1'b0, 0);
      total++; if (out !== m_out) $display("FAIL b2b out[%0d]: got %b want %b", i, out, m_out); else passed++;
      total++; if (out_valid !== 1'b1) $display("FAIL b2b out_valid[%0d]: got %b want 1", i, out_valid); else passed++;
    end
  endtask

  task automatic test_thr_load();
    cycle(1'b1, 1'b1, 5, 1'b1, 5);
    total++; if (out !== ref_cmp(5, TD)) $display("FAIL load-coincide out: got %b want %b", out, ref_cmp(5, TD)); else passed++;
    total++; if (thr !== 4'd5) $display("FAIL load thr: got %0d want 5", thr); else passed++;
    cycle(1'b1, 1'b1, 5, 1'b0, 0);
    total++; if (out !== 3'b010) $display("FAIL load-after out: got %b want 010", out); else passed++;
  endtask

  task automatic test_extremes();
    cycle(1'b1, 1'b0, 0, 1'b1, MAXV);
    cycle(1'b1, 1'b1, MAXV, 1'b0, 0);
    total++; if (out !== 3'b010) $display("FAIL max==max out: got %b want 010", out); else passed++;
    cycle(1'b1, 1'b1, 0, 1'b0, 0);
    total++; if (out !== m_out) $display("FAIL 0 vs max out: got %b want %b", out, m_out); else passed++;
    cycle(1'b1, 1'b0, 0, 1'b1, 0);
    cycle(1'b1, 1'b1, 0, 1'b0, 0);
    total++; if (out !== 3'b010) $display("FAIL 0==0 out: got %b want 010", out); else passed++;
    cycle(1'b1, 1'b1, 1, 1'b0, 0);
    total++; if (out !== 3'b100) $display("FAIL 1 vs 0 out: got %b want 100", out); else passed++;
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b0, 0, 1'b1, 5);
    cycle(1'b0, 1'b1, 9, 1'b1, 3);
    total++; if (out !== 3'b000) $display("FAIL midreset out: got %b want 000", out); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL midreset out_valid: got %b want 0", out_valid); else passed++;
    total++; if (thr !== 4'd8) $display("FAIL midreset thr: got %0d want 8", thr); else passed++;
    cycle(1'b1, 1'b1, 5, 1'b0, 0);
`ifdef INEQUALITY_CMP_SIGNED_EN
    total++; if (out !== 3'b100) $display("FAIL signed 5 vs -8 out: got %b want 100", out); else passed++;
`else
    total++; if (out !== 3'b001) $display("FAIL unsigned 5 vs 8 out: got %b want 001", out); else passed++;
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      cycle(($urandom_range(0, 31) != 0), $urandom_range(0, 1) == 1, $urandom_range(0, MAXV),
            $urandom_range(0, 3) == 0, $urandom_range(0, MAXV));
      total++;
      if (out !== m_out || out_valid !== m_valid || thr !== W'(m_thr))
        $display("FAIL random[%0d]: got out=%b v=%b thr=%0d want out=%b v=%b thr=%0d",
                 k, out, out_valid, thr, m_out, m_valid, m_thr);
      else passed++;
    end
  endtask

  initial begin
    m_thr   = TD % (1 << W);
    m_out   = 3'b000;
    m_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_thr_load();
    test_extremes();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/inequality_cmp.md
Name: inequality_cmp

Overview:
Registered magnitude comparator. Compares a WIDTH-bit input sample against an internal threshold register and returns a one-hot 3-bit result: greater-than, equal or less-than. Used as a small status/decision stage wherever a datapath value must be classified against a software- or config-loadable limit.

Parameters:
WIDTH, 4, bit width of the input sample and the threshold
THRESH_DEFAULT, 8, threshold value loaded at reset; unsigned in the default build

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
num_valid  input  1  qualifies num for comparison this cycle
num  input  WIDTH  sample to classify
thr_load  input  1  load thr_in into the threshold register this cycle
thr_in  input  WIDTH  new threshold value
out_valid  output  1  one-cycle pulse: out was updated on this edge
out  output  3  result; [2]=num>thr, [1]=num==thr, [0]=num<thr
thr  output  WIDTH  current threshold register contents

Behaviour:
- One clock (clk); reset is synchronous, active-low (rst_n), sampled on the rising edge of clk.
- Reset values: out=3'b000, out_valid=0, thr=THRESH_DEFAULT[WIDTH-1:0].
- Comparison is unsigned by default and covers the full WIDTH, with no truncation.
- On an edge with num_valid=1:
  - out <= {num>thr, num==thr, num<thr}, using the threshold value held before that edge.
  - out_valid <= 1.
- On an edge with num_valid=0: out holds its previous value; out_valid <= 0.
- Latency: 1 cycle from num_valid to out/out_valid.
- After the first valid sample, exactly one bit of out is set. out=000 only between reset and the first valid sample.
- Threshold load:
  - On an edge with thr_load=1, thr <= thr_in.
  - The new threshold takes effect for samples presented on the following cycle.
  - When thr_load and num_valid coincide, the comparison uses the old threshold.
- Boundaries: num=0 with thr=0 gives 010; num=2^WIDTH-1 with thr=2^WIDTH-1 gives 010. No wrap-around, since comparison is pure magnitude.
- Reset mid-operation: reset has priority over num_valid and thr_load. All registers return to reset values on that edge, and in-flight results are discarded.
- No internal state machine; the block is two registers plus combinational compare logic.

Optional Feature:
- Macro INEQUALITY_CMP_SIGNED_EN.
- When defined: num, thr_in and thr are interpreted as two's complement, and the comparison is signed. THRESH_DEFAULT is then interpreted as signed; for example, 8 at WIDTH=4 means -8.
- When undefined: unsigned comparison as described above.
- Ports, latency and handshake are identical in both builds.

Decomposition:
- Package inequality_cmp_pkg:
  - constants GT_BIT=2, EQ_BIT=1, LT_BIT=0;
  - typedef cmp_result_t (3-bit packed);
  - constant CMP_NONE=3'b000.
- One combinational sub-module, inequality_core: inputs a, b (WIDTH); output cmp_result_t. It holds the signed/unsigned selection under the macro.
- The top level holds the threshold register, the result register and the valid pulse.

Test Plan:
1. Hold rst_n=0 for 2 cycles -> out=000, out_valid=0, thr=8.
2. num=5, num_valid=1 for one cycle -> next edge out=001, out_valid=1; the following idle cycle gives out=001 held, out_valid=0.
3. Back-to-back samples num=8, 15, 0 -> out=010, 100, 001 on consecutive cycles, out_valid high throughout.
4. thr_load=1, thr_in=5 in the same cycle as num=5 valid -> out=001 (old thr=8). Then num=5 valid -> out=010, thr=5.
5. Extremes with thr loaded to 15: num=15 -> 010, num=0 -> 001. Then load thr=0: num=0 -> 010, num=1 -> 100.
6. rst_n=0 asserted while num_valid=1 and thr=5 -> next edge out=000, out_valid=0, thr=8. With INEQUALITY_CMP_SIGNED_EN: num=5 vs default thr -> out=100.
